targ_fb_queue: RTL and testbench
================================

# targ_fb_queue

Feedback-side companion to the target predictor. Collects resolved indirect-branch outcomes (base PC, actual target) from up to `core::peval_width` execution lanes per cycle, discards wrong-path and duplicate reports, buffers them in a FIFO, and drains at most one per cycle onto the predictor's `core::targ_pred_fb_t` feedback port. It sits between the branch-resolution stage and the predictor and decouples multi-lane resolution bursts from the predictor's single update per cycle.

## Interface
- `depth`, 8: FIFO entries; power of two, must be >= 2 * `core::peval_width`
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `en` in 1: predictor enable; drain happens only while high
- `flush` in 1: pipeline squash; discards all queued and same-cycle reports
- `res_valid[core::peval_width]` in `bool_t`: lane i reports a resolved indirect branch
- `res_base_pc[core::peval_width]` in `sys::addr_t`: branch PC for lane i
- `res_targ_pc[core::peval_width]` in `sys::addr_t`: resolved target for lane i
- `res_ready` out 1: queue can accept a full burst of lanes this cycle
- `fb` out `core::targ_pred_fb_t`: `valid`, `base_pc`, `targ_pc` to the predictor
- `occ` out `$clog2(depth)+1`: current entry count (registered)
- `drop_cnt` out 16: saturating count of overflow-dropped reports

## Operation
- Storage: circular buffer of `depth` {base_pc, targ_pc}; head/tail pointers `$clog2(depth)` bits, wrap modulo `depth`; count register `occ`.
- Drain: `fb.valid = en && !flush && (occ != 0)`; `fb.base_pc`/`fb.targ_pc` = head entry (driven straight from storage, no extra register). Pop occurs in the same cycle `fb.valid` is high; the predictor consumes unconditionally.
- When `fb.valid` is low, `fb.base_pc`/`fb.targ_pc` = 0.
- Enqueue: lanes are processed in ascending lane index; each accepted lane takes the next tail slot, so lane order is preserved in the FIFO.
- Dedup: a valid lane is silently dropped (not counted) if its {base_pc, targ_pc} equals (a) any lower-index valid lane in the same cycle, or (b) the most recently enqueued entry still present in the FIFO (last written slot, only if `occ != 0` after the current-cycle pop).
- `res_ready = (depth - occ) >= core::peval_width`, from registered `occ` only; ignores same-cycle pop.
- Overflow: if `res_ready` is low, every valid, non-duplicate lane is dropped and `drop_cnt` increments by the number dropped; it saturates at 16'hFFFF. No partial acceptance.
- Flush: clears head, tail and `occ` to 0; same-cycle lanes are discarded (not counted); no pop or `fb.valid` that cycle. Flush dominates enqueue and drain. `drop_cnt` is not cleared by flush.
- Simultaneous pop and enqueue: `occ_next = occ - pop + accepted`. A pop of the same slot the dedup check (b) would compare against makes (b) inapplicable, since the queue becomes empty.
- Reset: head = tail = `occ` = 0, `drop_cnt` = 0, `fb.valid` = 0, `res_ready` = 1. Reset mid-burst drops all contents; reset dominates flush.

## Timing
- Enqueue-to-feedback latency: a report accepted in cycle N can appear on `fb` at the earliest in cycle N+1, when the queue was empty and `en` = 1.
- Throughput: 1 drain per cycle with `en` high; up to `core::peval_width` enqueues per cycle.
- `occ`, `drop_cnt` and `res_ready` reflect state after the previous clock edge.
- `en` low stalls drain only; enqueue, dedup and flush operate regardless of `en`.
- Storage updates on `posedge clk` only; `fb` is combinational from registered state plus `en`/`flush`.

## Test plan
- Reset, then 3 cycles idle with `peval_width` = 4, `depth` = 8 -> `fb.valid` = 0, `occ` = 0, `res_ready` = 1, `drop_cnt` = 0.
- Cycle 0: lanes 0..3 report PCs 0x100/0x200/0x300/0x400 with targets 0x1000/0x2000/0x3000/0x4000, `en` = 1 -> `fb` shows 0x100->0x1000 in cycle 1, then each remaining report in order in cycles 2-4; `occ` reads 4,3,2,1,0.
- Same cycle: lanes 0 and 2 both report 0x100->0x1000, lane 1 reports 0x100->0x1100 -> 2 entries enqueued (0x1000 then 0x1100); `drop_cnt` stays 0. Next cycle lane 0 reports 0x100->0x1100 again with `en` = 0 -> no new entry, `occ` stays 2.
- `en` = 0, fill with 4 + 4 distinct reports -> `occ` = 8, `res_ready` = 0; a third 4-lane burst -> `occ` stays 8, `drop_cnt` = 4; raise `en` -> 8 drains in FIFO order, and the pointers wrap correctly on the next fill.
- `occ` = 5 and a burst of 2 with `flush` = 1 and `en` = 1 -> next cycle `occ` = 0, `fb.valid` = 0 in the flush cycle and after, `drop_cnt` unchanged.
- Force `drop_cnt` toward saturation (65535 dropped lanes) then drop 4 more -> `drop_cnt` holds 16'hFFFF; assert `rst` mid-drain -> all outputs return to their reset values on the next cycle.

Source files
------------

// File: rtl/targ_fb_queue.sv
// rtl/targ_fb_queue.sv - indirect-branch target feedback queue
// Merges multi-lane resolution reports into a deduplicating FIFO drained one entry per cycle.
module targ_fb_queue #(
   parameter int DEPTH   = 8,
   parameter int PEVAL_W = 4,
   parameter int ADDR_W  = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_en,
   input  logic                             i_flush,
   input  logic [PEVAL_W-1:0]               i_res_valid,
   input  logic [PEVAL_W-1:0][ADDR_W-1:0]   i_res_base_pc,
   input  logic [PEVAL_W-1:0][ADDR_W-1:0]   i_res_targ_pc,
   output logic                             o_res_ready,
   output logic                             o_fb_valid,
   output logic [ADDR_W-1:0]                o_fb_base_pc,
   output logic [ADDR_W-1:0]                o_fb_targ_pc,
   output logic [$clog2(DEPTH):0]           o_occ,
   output logic [15:0]                      o_drop_cnt
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;
   localparam int LW    = $clog2(PEVAL_W + 1);

   logic [ADDR_W-1:0] r_base [DEPTH];
   logic [ADDR_W-1:0] r_targ [DEPTH];
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CW-1:0]     r_occ;
   logic [15:0]       r_drop;

   logic              w_pop;
   logic              w_acc;
   logic              w_last_live;
   logic [PTR_W-1:0]  w_last_idx;
   logic [PEVAL_W-1:0] w_uniq;
   logic [PTR_W-1:0]  w_slot [PEVAL_W];
   logic [LW-1:0]     w_nuniq;
   logic [16:0]       w_drop_sum;

   assign o_res_ready = (CW'(DEPTH) - r_occ) >= CW'(PEVAL_W);
   assign w_pop       = i_en && !i_flush && (r_occ != '0);
   assign w_acc       = o_res_ready && !i_flush;
   assign w_last_idx  = r_tail - PTR_W'(1);
   // The newest entry only counts for dedup if it survives this cycle's pop.
   assign w_last_live = (r_occ - CW'(w_pop)) != '0;
   assign w_drop_sum  = {1'b0, r_drop} + 17'(w_nuniq);

   assign o_fb_valid   = w_pop;
   assign o_fb_base_pc = w_pop ? r_base[r_head] : '0;
   assign o_fb_targ_pc = w_pop ? r_targ[r_head] : '0;
   assign o_occ        = r_occ;
   assign o_drop_cnt   = r_drop;

   always_comb begin
      logic [LW-1:0] v_cnt;
      v_cnt  = '0;
      w_uniq = '0;
      for (int i = 0; i < PEVAL_W; i++) begin
         w_slot[i] = r_tail + PTR_W'(v_cnt);
         w_uniq[i] = i_res_valid[i];
         for (int j = 0; j < PEVAL_W; j++) begin
            if (j < i && i_res_valid[j] &&
                i_res_base_pc[j] == i_res_base_pc[i] &&
                i_res_targ_pc[j] == i_res_targ_pc[i])
               w_uniq[i] = 1'b0;
         end
         if (w_last_live &&
             r_base[w_last_idx] == i_res_base_pc[i] &&
             r_targ[w_last_idx] == i_res_targ_pc[i])
            w_uniq[i] = 1'b0;
         v_cnt = v_cnt + LW'(w_uniq[i]);
      end
      w_nuniq = v_cnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= '0;
         r_drop <= '0;
      end else if (i_flush) begin
         r_head <= '0;
         r_tail <= '0;
         r_occ  <= '0;
      end else begin
         r_head <= r_head + PTR_W'(w_pop);
         if (w_acc) begin
            r_tail <= r_tail + PTR_W'(w_nuniq);
         end
         r_occ <= r_occ - CW'(w_pop) + (w_acc ? CW'(w_nuniq) : CW'(0));
         if (!o_res_ready && w_nuniq != '0) begin
            r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < PEVAL_W; i++) begin
         if (!rst && w_acc && w_uniq[i]) begin
            r_base[w_slot[i]] <= i_res_base_pc[i];
            r_targ[w_slot[i]] <= i_res_targ_pc[i];
         end
      end
   end
endmodule

// File: tb/tb_targ_fb_queue.sv
// tb/tb_targ_fb_queue.sv - scoreboard bench for targ_fb_queue
// Queue-based reference model predicts each cycle's outputs; a monitor compares them.
module tb_targ_fb_queue;
   localparam int DEPTH = 8;
   localparam int PW    = 4;
   localparam int AW    = 32;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 i_en = 1'b0;
   logic                 i_flush = 1'b0;
   logic [PW-1:0]        i_res_valid = '0;
   logic [PW-1:0][AW-1:0] i_res_base_pc = '0;
   logic [PW-1:0][AW-1:0] i_res_targ_pc = '0;
   logic                 o_res_ready;
   logic                 o_fb_valid;
   logic [AW-1:0]        o_fb_base_pc;
   logic [AW-1:0]        o_fb_targ_pc;
   logic [3:0]           o_occ;
   logic [15:0]          o_drop_cnt;

   targ_fb_queue #(.DEPTH(DEPTH), .PEVAL_W(PW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .i_en(i_en), .i_flush(i_flush),
      .i_res_valid(i_res_valid), .i_res_base_pc(i_res_base_pc), .i_res_targ_pc(i_res_targ_pc),
      .o_res_ready(o_res_ready), .o_fb_valid(o_fb_valid),
      .o_fb_base_pc(o_fb_base_pc), .o_fb_targ_pc(o_fb_targ_pc),
      .o_occ(o_occ), .o_drop_cnt(o_drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] b;
      logic [31:0] t;
   } ent_t;

   typedef struct {
      bit          skip;
      bit          v;
      logic [31:0] b;
      logic [31:0] t;
      int          occ;
      bit          rdy;
      int          drop;
   } exp_t;

   ent_t mq[$];
   exp_t exp_q[$];
   int   mdrop = 0;
   int   n_cmp = 0;
   int   n_fail = 0;

   logic [PW-1:0] lv;
   logic [31:0]   lb [PW];
   logic [31:0]   lt [PW];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic set_lanes(input logic [PW-1:0] v, input logic [31:0] b0, input logic [31:0] t0);
      lv = v;
      for (int i = 0; i < PW; i++) begin
         lb[i] = b0 + 32'(i) * 32'h100;
         lt[i] = t0 + 32'(i) * 32'h1000;
      end
   endtask

   task automatic tick(input bit r, input bit e, input bit f);
      exp_t x;
      ent_t last;
      ent_t cands[$];
      bit   have_last;
      bit   dup;
      @(negedge clk);
      rst = r;
      i_en = e;
      i_flush = f;
      i_res_valid = lv;
      for (int i = 0; i < PW; i++) begin
         i_res_base_pc[i] = lb[i];
         i_res_targ_pc[i] = lt[i];
      end
      x.skip = r;
      x.v = 1'b0;
      x.b = '0;
      x.t = '0;
      x.occ = mq.size();
      x.rdy = (DEPTH - mq.size()) >= PW;
      x.drop = mdrop;
      if (r) begin
         mq.delete();
         mdrop = 0;
      end else if (f) begin
         mq.delete();
      end else begin
         if (e && mq.size() > 0) begin
            x.v = 1'b1;
            x.b = mq[0].b;
            x.t = mq[0].t;
            void'(mq.pop_front());
         end
         have_last = mq.size() > 0;
         if (have_last) last = mq[$];
         for (int i = 0; i < PW; i++) begin
            if (lv[i]) begin
               dup = 1'b0;
               for (int j = 0; j < i; j++)
                  if (lv[j] && lb[j] == lb[i] && lt[j] == lt[i]) dup = 1'b1;
               if (have_last && last.b == lb[i] && last.t == lt[i]) dup = 1'b1;
               if (!dup) cands.push_back('{b: lb[i], t: lt[i]});
            end
         end
         if (x.rdy) begin
            foreach (cands[k]) mq.push_back(cands[k]);
         end else begin
            mdrop = mdrop + cands.size();
            if (mdrop > 65535) mdrop = 65535;
         end
      end
      exp_q.push_back(x);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            if (!x.skip) begin
               chk("fb_valid", 64'(o_fb_valid), 64'(x.v));
               chk("fb_base_pc", 64'(o_fb_base_pc), 64'(x.b));
               chk("fb_targ_pc", 64'(o_fb_targ_pc), 64'(x.t));
               chk("occ", 64'(o_occ), 64'(x.occ));
               chk("res_ready", 64'(o_res_ready), 64'(x.rdy));
               chk("drop_cnt", 64'(o_drop_cnt), 64'(x.drop));
            end
         end
      end
   end

   initial begin : driver
      bit e_mode;
      set_lanes('0, 32'h0, 32'h0);
      tick(1, 0, 0);
      tick(1, 0, 0);
      repeat (3) tick(0, 0, 0);

      set_lanes(4'hF, 32'h100, 32'h1000);
      tick(0, 1, 0);
      set_lanes('0, 32'h0, 32'h0);
      repeat (5) tick(0, 1, 0);

      lv = 4'b0111;
      lb[0] = 32'h100; lt[0] = 32'h1000;
      lb[1] = 32'h100; lt[1] = 32'h1100;
      lb[2] = 32'h100; lt[2] = 32'h1000;
      lb[3] = 32'h0;   lt[3] = 32'h0;
      tick(0, 0, 0);
      lv = 4'b0001;
      lb[0] = 32'h100; lt[0] = 32'h1100;
      tick(0, 0, 0);
      set_lanes('0, 32'h0, 32'h0);
      repeat (3) tick(0, 1, 0);

      set_lanes(4'hF, 32'h500, 32'h5000);
      tick(0, 0, 0);
      set_lanes(4'hF, 32'h900, 32'h9000);
      tick(0, 0, 0);
      set_lanes(4'hF, 32'hD00, 32'hD000);
      tick(0, 0, 0);
      set_lanes('0, 32'h0, 32'h0);
      repeat (10) tick(0, 1, 0);
      set_lanes(4'hF, 32'h2100, 32'h21000);
      tick(0, 1, 0);
      set_lanes('0, 32'h0, 32'h0);
      repeat (6) tick(0, 1, 0);

      set_lanes(4'hF, 32'h3100, 32'h31000);
      tick(0, 0, 0);
      set_lanes(4'h1, 32'h4100, 32'h41000);
      tick(0, 0, 0);
      set_lanes(4'h3, 32'h5100, 32'h51000);
      tick(0, 1, 1);
      set_lanes('0, 32'h0, 32'h0);
      repeat (2) tick(0, 1, 0);

      set_lanes(4'hF, 32'h6100, 32'h61000);
      tick(0, 0, 0);
      set_lanes(4'hF, 32'h7100, 32'h71000);
      tick(0, 0, 0);
      set_lanes(4'hF, 32'h8100, 32'h81000);
      repeat (16385) tick(0, 0, 0);
      tick(0, 0, 0);
      set_lanes('0, 32'h0, 32'h0);
      repeat (3) tick(0, 1, 0);
      tick(1, 1, 0);
      repeat (2) tick(0, 1, 0);

      e_mode = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if (c % 150 == 0) e_mode = ($urandom_range(0, 1) == 1);
         lv = 4'($urandom);
         for (int i = 0; i < PW; i++) begin
            lb[i] = 32'h100 * 32'($urandom_range(1, 4));
            lt[i] = 32'h1000 + 32'h100 * 32'($urandom_range(0, 2));
         end
         tick(($urandom_range(0, 499) == 0), e_mode ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 39) == 0));
      end
      set_lanes('0, 32'h0, 32'h0);
      repeat (10) tick(0, 1, 0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
